// File: rtl/usb_cmd_pkg.sv
// Shared constants and state encoding for the USB command-to-AXI-Lite initiator.
package usb_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] ST_BADOP = 8'hFF;

  localparam logic [2:0] WR_RESP_LEN    = 3'd1;
  localparam logic [2:0] RD_RESP_LEN    = 3'd5;
  localparam logic [2:0] BADOP_RESP_LEN = 3'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_TX
  } state_t;

endpackage

// File: rtl/usb_cmd_tx_ser.sv
// Response serializer: loads up to 5 bytes and emits them LSB first on a valid/ready byte stream.
module usb_cmd_tx_ser (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [39:0] data,
  input  logic [2:0]  len,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        done
);

  logic [31:0] shreg;
  logic [2:0]  remain;

  assign done = tx_tvalid && tx_tready && (remain == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_tdata  <= '0;
      tx_tvalid <= 1'b0;
      shreg     <= '0;
      remain    <= '0;
    end else if (start) begin
      tx_tdata  <= data[7:0];
      shreg     <= data[39:8];
      remain    <= len - 3'd1;
      tx_tvalid <= 1'b1;
    end else if (tx_tvalid && tx_tready) begin
      if (remain == '0) begin
        tx_tvalid <= 1'b0;
      end else begin
        tx_tdata <= shreg[7:0];
        shreg    <= {8'h00, shreg[31:8]};
        remain   <= remain - 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_cmd_axil_master.sv
// Parses USB command bytes into single AXI-Lite transactions and streams the response back.
module usb_cmd_axil_master
  import usb_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned RX_TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_tdata,
  input  logic              rx_tvalid,
  output logic              rx_tready,
  output logic [7:0]        tx_tdata,
  output logic              tx_tvalid,
  input  logic              tx_tready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic              busy,
  output logic              rx_timeout_pulse
);

  state_t state, next_state;

  logic              rx_en, is_write, tx_start, tx_done;
  logic              accept, capturing, tmo_hit, aw_done, w_done;
  logic [1:0]        byte_cnt;
  logic [7:0]        addr_lo;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, tmo_cnt;
  logic [39:0]       resp_data;
  logic [2:0]        resp_len;

  assign accept    = rx_tvalid && rx_tready;
  assign capturing = (state == S_ADDR) || (state == S_DATA);
  assign tmo_hit   = (RX_TIMEOUT != 0) && (tmo_cnt == RX_TIMEOUT - 1);
  assign aw_done   = !m_axi_awvalid || m_axi_awready;
  assign w_done    = !m_axi_wvalid || m_axi_wready;

  // rx_tready is registered from next_state so it stays low while reset is held.
  assign rx_tready     = rx_en;
  assign busy          = (state != S_IDLE);
  assign m_axi_bready  = (state == S_WR_RESP);
  assign m_axi_rready  = (state == S_RD_RESP);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (rx_tdata == OP_WRITE || rx_tdata == OP_READ) next_state = S_ADDR;
          else                                             next_state = S_TX;
        end
      end
      S_ADDR: begin
        if (accept && byte_cnt[0]) next_state = is_write ? S_DATA : S_RD_REQ;
        else if (!accept && tmo_hit) next_state = S_IDLE;
      end
      S_DATA: begin
        if (accept && byte_cnt == 2'd3) next_state = S_WR_REQ;
        else if (!accept && tmo_hit)    next_state = S_IDLE;
      end
      S_WR_REQ:  if (aw_done && w_done) next_state = S_WR_RESP;
      S_WR_RESP: if (m_axi_bvalid)      next_state = S_TX;
      S_RD_REQ:  if (m_axi_arready)     next_state = S_RD_RESP;
      S_RD_RESP: if (m_axi_rvalid)      next_state = S_TX;
      S_TX:      if (tx_done)           next_state = S_IDLE;
      default:                          next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_en            <= 1'b0;
      is_write         <= 1'b0;
      byte_cnt         <= '0;
      addr_lo          <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      tmo_cnt          <= '0;
      rx_timeout_pulse <= 1'b0;
      m_axi_awvalid    <= 1'b0;
      m_axi_wvalid     <= 1'b0;
      m_axi_arvalid    <= 1'b0;
      resp_data        <= '0;
      resp_len         <= '0;
      tx_start         <= 1'b0;
    end else begin
      rx_en            <= (next_state == S_IDLE) || (next_state == S_ADDR) || (next_state == S_DATA);
      rx_timeout_pulse <= capturing && (next_state == S_IDLE);
      tx_start         <= (next_state == S_TX) && (state != S_TX);

      if (capturing && !accept) tmo_cnt <= tmo_cnt + 32'd1;
      else                      tmo_cnt <= '0;

      if (state == S_IDLE)      byte_cnt <= '0;
      else if (accept)          byte_cnt <= (next_state != state) ? 2'd0 : byte_cnt + 2'd1;

      if (accept) begin
        case (state)
          S_IDLE: is_write <= (rx_tdata == OP_WRITE);
          S_ADDR: begin
            if (byte_cnt[0]) addr_q  <= ADDR_W'({rx_tdata, addr_lo});
            else             addr_lo <= rx_tdata;
          end
          S_DATA: wdata_q <= {rx_tdata, wdata_q[31:8]};
          default: ;
        endcase
      end

      // Each write channel valid drops on its own handshake, independent of the other.
      if (next_state == S_WR_REQ && state != S_WR_REQ) begin
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
      end else begin
        if (m_axi_awready) m_axi_awvalid <= 1'b0;
        if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
      end

      if (next_state == S_RD_REQ && state != S_RD_REQ) m_axi_arvalid <= 1'b1;
      else if (m_axi_arready)                          m_axi_arvalid <= 1'b0;

      if (state == S_IDLE && accept && next_state == S_TX) begin
        resp_data <= {32'd0, ST_BADOP};
        resp_len  <= BADOP_RESP_LEN;
      end else if (state == S_WR_RESP && m_axi_bvalid) begin
        resp_data <= {32'd0, 6'd0, m_axi_bresp};
        resp_len  <= WR_RESP_LEN;
      end else if (state == S_RD_RESP && m_axi_rvalid) begin
        resp_data <= {6'd0, m_axi_rresp, m_axi_rdata};
        resp_len  <= RD_RESP_LEN;
      end
    end
  end

  usb_cmd_tx_ser u_tx_ser (
    .clk       (clk),
    .rstn      (rstn),
    .start     (tx_start),
    .data      (resp_data),
    .len       (resp_len),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .done      (tx_done)
  );

endmodule

// File: tb/tb_usb_cmd_axil_master.sv
// Self-checking bench: directed and random commands against a byte-level reference model.
module tb_usb_cmd_axil_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_tdata;
  logic        rx_tvalid;
  logic        rx_tready;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tready;
  logic [14:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [14:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic        busy;
  logic        rx_timeout_pulse;

  always #5 clk = ~clk;

  usb_cmd_axil_master #(.ADDR_W(15), .RX_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .busy(busy), .rx_timeout_pulse(rx_timeout_pulse)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // Slave behaviour knobs and observed handshakes.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
  logic [31:0] rdata_cfg = '0;
  int          aw_n = 0, w_n = 0, ar_n = 0, proto_err = 0, tx_valid_seen = 0;
  logic [14:0] aw_addr_got = '0, ar_addr_got = '0;
  logic [31:0] w_data_got = '0;
  logic [3:0]  w_strb_got = '0;
  int unsigned aw_cyc = 0, w_cyc = 0;
  logic        aw_at_w = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0, b_cnt = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    end else begin
      if (p_awv && !p_awr && !m_axi_awvalid) proto_err++;
      if (p_wv && !p_wr && !m_axi_wvalid)    proto_err++;
      if (p_arv && !p_arr && !m_axi_arvalid) proto_err++;
      if (tx_tvalid) tx_valid_seen++;

      if (m_axi_awvalid) begin
        if (aw_cnt >= aw_delay) begin
          m_axi_awready = 1; aw_n++; aw_addr_got = m_axi_awaddr; aw_cyc = cyc;
        end else begin
          m_axi_awready = 0; aw_cnt++;
        end
      end else begin
        m_axi_awready = 0; aw_cnt = 0;
      end

      if (m_axi_wvalid) begin
        if (w_cnt >= w_delay) begin
          m_axi_wready = 1; w_n++; w_data_got = m_axi_wdata; w_strb_got = m_axi_wstrb;
          w_cyc = cyc; aw_at_w = m_axi_awvalid;
        end else begin
          m_axi_wready = 0; w_cnt++;
        end
      end else begin
        m_axi_wready = 0; w_cnt = 0;
      end

      if (m_axi_arvalid) begin
        if (ar_cnt >= ar_delay) begin
          m_axi_arready = 1; ar_n++; ar_addr_got = m_axi_araddr;
        end else begin
          m_axi_arready = 0; ar_cnt++;
        end
      end else begin
        m_axi_arready = 0; ar_cnt = 0;
      end

      if (m_axi_bready) begin
        if (b_cnt >= b_delay) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; end
        else begin m_axi_bvalid = 0; b_cnt++; end
      end else begin
        m_axi_bvalid = 0; b_cnt = 0;
      end

      if (m_axi_rready) begin
        if (r_cnt >= r_delay) begin m_axi_rvalid = 1; m_axi_rdata = rdata_cfg; m_axi_rresp = rresp_cfg; end
        else begin m_axi_rvalid = 0; r_cnt++; end
      end else begin
        m_axi_rvalid = 0; r_cnt = 0;
      end

      p_awv = m_axi_awvalid; p_awr = m_axi_awready;
      p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pack(input logic [7:0] q[$]);
    logic [39:0] v = '0;
    foreach (q[i]) if (i < 5) v[8*i +: 8] = q[i];
    return v;
  endfunction

  logic [7:0] cmd_q[$];
  logic [7:0] got_q[$];

  // Called at a negedge; returns at the negedge after the last byte is taken.
  task automatic send_cmd();
    int   t;
    logic acc;
    foreach (cmd_q[i]) begin
      rx_tdata  = cmd_q[i];
      rx_tvalid = 1'b1;
      t = 0;
      do begin
        acc = rx_tready;
        @(negedge clk);
        t++;
      end while (!acc && t < 100);
      if (!acc) chk("rx_accept_bound", 64'd0, 64'd1);
    end
    rx_tvalid = 1'b0;
    rx_tdata  = '0;
  endtask

  // mode 0: always ready, 1: toggling, 2: random
  task automatic wait_resp(input int n, input int mode);
    int         t = 0, stab_err = 0;
    logic       stall = 0;
    logic [7:0] pd = '0;
    got_q.delete();
    while (got_q.size() < n && t < 300) begin
      if (stall && (!tx_tvalid || tx_tdata !== pd)) stab_err++;
      tx_tready = (mode == 0) ? 1'b1 : (mode == 1) ? t[0] : 1'($urandom_range(0, 1));
      if (tx_tvalid && tx_tready) got_q.push_back(tx_tdata);
      stall = tx_tvalid && !tx_tready;
      pd    = tx_tdata;
      @(negedge clk);
      t++;
    end
    tx_tready = 1'b0;
    chk("tx_count", 64'(got_q.size()), 64'(n));
    chk("tx_stable", 64'(stab_err), 64'd0);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] data,
                         input int mode, input string tag);
    logic [7:0] exp_q[$];
    int aw0 = aw_n, w0 = w_n, ar0 = ar_n;
    cmd_q.delete();
    cmd_q.push_back(op);
    if (op == 8'h01 || op == 8'h02) begin
      cmd_q.push_back(addr[7:0]);
      cmd_q.push_back(addr[15:8]);
    end
    if (op == 8'h01) for (int i = 0; i < 4; i++) cmd_q.push_back(8'((data >> (8 * i)) & 32'hFF));

    if (op == 8'h01) exp_q.push_back({6'd0, bresp_cfg});
    else if (op == 8'h02) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((rdata_cfg >> (8 * i)) & 32'hFF));
      exp_q.push_back({6'd0, rresp_cfg});
    end else exp_q.push_back(8'hFF);

    send_cmd();
    wait_resp(exp_q.size(), mode);
    chk({tag, "_tx_bytes"}, 64'(pack(got_q)), 64'(pack(exp_q)));
    chk({tag, "_idle_ready"}, {61'd0, busy, rx_tready, tx_tvalid}, 64'b010);

    if (op == 8'h01) begin
      chk({tag, "_axi_counts"}, {32'(aw_n - aw0), 16'(w_n - w0), 16'(ar_n - ar0)}, {32'd1, 16'd1, 16'd0});
      chk({tag, "_awaddr"}, 64'(aw_addr_got), 64'(addr % 16'h8000));
      chk({tag, "_wdata"}, {28'd0, w_strb_got, w_data_got}, {28'd0, 4'hF, data});
    end else if (op == 8'h02) begin
      chk({tag, "_axi_counts"}, {32'(aw_n - aw0), 16'(w_n - w0), 16'(ar_n - ar0)}, {32'd0, 16'd0, 16'd1});
      chk({tag, "_araddr"}, 64'(ar_addr_got), 64'(addr % 16'h8000));
    end else begin
      chk({tag, "_axi_counts"}, {32'(aw_n - aw0), 16'(w_n - w0), 16'(ar_n - ar0)}, 64'd0);
    end
  endtask

  initial begin
    int t, v0, a0, w0, r0;
    rstn = 0; rx_tdata = 0; rx_tvalid = 0; tx_tready = 0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {55'd0, rx_tready, tx_tvalid, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                     m_axi_bready, m_axi_rready, busy, rx_timeout_pulse}, 64'd0);
    chk("rst_tdata", 64'(tx_tdata), 64'd0);
    chk("rst_addr_data", {2'd0, m_axi_awaddr, m_axi_araddr, m_axi_wdata}, 64'd0);
    rstn = 1;
    @(negedge clk);

    run_cmd(8'h01, 16'h0084, 32'hDEADBEEF, 0, "wr_same");
    chk("wr_same_cycle", 64'(w_cyc - aw_cyc), 64'd0);

    ar_delay = 3; r_delay = 5; rdata_cfg = 32'h12345678; rresp_cfg = 2'd0;
    run_cmd(8'h02, 16'h0010, 32'd0, 0, "rd_delay");

    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 4; bresp_cfg = 2'd2;
    run_cmd(8'h01, 16'h8234, 32'hCAFEF00D, 0, "wr_split");
    chk("wr_split_gap", 64'(w_cyc - aw_cyc), 64'd4);
    chk("wr_split_aw_dropped", 64'(aw_at_w), 64'd0);

    w_delay = 0; ar_delay = 1; r_delay = 1; rdata_cfg = 32'hA1B2C3D4; rresp_cfg = 2'd1;
    run_cmd(8'h02, 16'hFFFF, 32'd0, 1, "rd_bp");
    rdata_cfg = 32'h0BADF00D; rresp_cfg = 2'd3;
    run_cmd(8'h02, 16'h0001, 32'd0, 0, "b2b");

    run_cmd(8'h5A, 16'd0, 32'd0, 0, "badop");

    v0 = tx_valid_seen; a0 = aw_n; w0 = w_n; r0 = ar_n;
    cmd_q.delete(); cmd_q.push_back(8'h01); cmd_q.push_back(8'h20);
    send_cmd();
    t = 0;
    while (!rx_timeout_pulse && t < 40) begin @(negedge clk); t++; end
    chk("tmo_delay", 64'(t), 64'd16);
    @(negedge clk);
    chk("tmo_pulse_width", {62'd0, rx_timeout_pulse, busy}, 64'd0);
    repeat (4) @(negedge clk);
    chk("tmo_no_traffic", {16'(tx_valid_seen - v0), 16'(aw_n - a0), 16'(w_n - w0), 16'(ar_n - r0)}, 64'd0);
    rdata_cfg = 32'h00C0FFEE; rresp_cfg = 2'd0;
    run_cmd(8'h02, 16'h0000, 32'd0, 0, "after_tmo");

    for (int k = 0; k < 16; k++) begin
      int          sel;
      logic [7:0]  op;
      sel = int'($urandom_range(0, 9));
      op  = (sel <= 3) ? 8'h01 : (sel <= 7) ? 8'h02 : 8'($urandom_range(3, 255));
      aw_delay = int'($urandom_range(0, 4)); w_delay = int'($urandom_range(0, 4));
      ar_delay = int'($urandom_range(0, 4)); r_delay = int'($urandom_range(0, 4));
      b_delay  = int'($urandom_range(0, 4));
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      rdata_cfg = $urandom;
      run_cmd(op, 16'($urandom), $urandom, 2, "rnd");
    end

    aw_delay = 1000; w_delay = 1000; b_delay = 0;
    cmd_q.delete();
    cmd_q = '{8'h01, 8'h42, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_cmd();
    t = 0;
    while (!m_axi_awvalid && t < 10) begin @(negedge clk); t++; end
    chk("rst_pre_awvalid", {62'd0, m_axi_awvalid, busy}, 64'b11);
    #2 rstn = 0;
    #1 chk("rst_async_drop", {61'd0, m_axi_awvalid, m_axi_wvalid, busy}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    aw_delay = 0; w_delay = 0; ar_delay = 0; r_delay = 0;
    rdata_cfg = 32'h5566AA77; rresp_cfg = 2'd0;
    @(negedge clk);
    run_cmd(8'h02, 16'h0055, 32'd0, 0, "post_rst");

    chk("axi_valid_hold", 64'(proto_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_cmd_axil_master.md
Name: usb_cmd_axil_master

Overview:
Command-side initiator for the register path. Parses the byte stream from the USB FIFO interface into single AXI-Lite read/write transactions and issues them on an AXI-Lite master port that connects to usb2reg_bridge's slave port. Serialises the response (read data plus status) back onto the USB transmit byte stream. Only one transaction is outstanding at a time.

Parameters:
ADDR_W, 15, AXI-Lite address width; upper bits of the received 16-bit address are dropped.
RX_TIMEOUT, 1000000, idle clk cycles between command bytes before a partial command is discarded; 0 disables the timeout.

Ports:
clk  in  1  single system clock
rstn  in  1  asynchronous active-low reset
rx_tdata  in  8  command byte from USB
rx_tvalid  in  1  command byte valid
rx_tready  out  1  block accepts command byte
tx_tdata  out  8  response byte to USB
tx_tvalid  out  1  response byte valid
tx_tready  in  1  USB accepts response byte
m_axi_awaddr  out  ADDR_W  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1
m_axi_wdata  out  32  write data
m_axi_wstrb  out  4  always 4'hF
m_axi_wvalid  out  1
m_axi_wready  in  1
m_axi_bresp  in  2
m_axi_bvalid  in  1
m_axi_bready  out  1
m_axi_araddr  out  ADDR_W  read address
m_axi_arvalid  out  1
m_axi_arready  in  1
m_axi_rdata  in  32
m_axi_rresp  in  2
m_axi_rvalid  in  1
m_axi_rready  out  1
busy  out  1  high whenever state != IDLE
rx_timeout_pulse  out  1  one-cycle pulse when a partial command is discarded

Behaviour:
- Reset: all valid and ready outputs are 0, tx_tdata=0, address/data registers=0, busy=0, rx_timeout_pulse=0, state=IDLE.
- Command format: byte0 is the opcode (0x01=WRITE, 0x02=READ). bytes1-2 are the address, little-endian; awaddr/araddr = addr16[ADDR_W-1:0]. WRITE only: bytes3-6 are data, little-endian.
- Response format: WRITE returns 1 byte {6'b0,bresp}. READ returns 4 rdata bytes, LSB first, then {6'b0,rresp}.
- Unknown opcode: the byte is consumed and the block sends the single byte 0xFF, then returns to IDLE.
- Byte capture: rx_tready=1 only in IDLE/ADDR/DATA states. A byte is captured on rx_tvalid&&rx_tready, one byte per cycle max.
- States: IDLE -> ADDR (2 bytes) -> DATA (4 bytes, WRITE only) -> WR_REQ or RD_REQ -> WR_RESP or RD_RESP -> TX -> IDLE. An unknown opcode goes IDLE -> TX.
- WR_REQ: awvalid and wvalid assert together in the cycle after the last data byte. Each valid drops independently on its own handshake. Advance to WR_RESP once both handshakes are done, including the same-cycle case.
- WR_RESP: bready=1. Capture bresp on bvalid.
- RD_REQ: arvalid=1 until arready. RD_RESP: rready=1. Capture rdata/rresp on rvalid.
- Valids never drop without a handshake. The block has no AXI timeout; a hung slave keeps busy=1 until reset.
- TX: byte counter 0..N-1 (N=1 for WRITE and unknown opcode, N=5 for READ). tx_tdata is registered and held stable while tx_tvalid&&!tx_tready. The counter advances on the handshake. Return to IDLE after the last byte's handshake, so back-to-back commands are accepted from the next cycle.
- First response byte: tx_tvalid rises the cycle after entering TX.
- Rx timeout: the counter clears on each accepted byte and runs only in ADDR/DATA. On reaching RX_TIMEOUT the block returns to IDLE, pulses rx_timeout_pulse, and sends no response. The counter is not active in AXI or TX states.
- Reset mid-transaction: all valids drop immediately (async). Any partial command or response is lost.

Decomposition:
- Shared package usb_cmd_pkg: opcode constants (OP_WRITE=8'h01, OP_READ=8'h02), status constant ST_BADOP=8'hFF, state enum encoding, response lengths.
- No sub-module required. The TX serializer is an optional sub-module usb_cmd_tx_ser: a 40-bit shift register plus count, with a valid/ready byte output.

Test Plan:
- Write: rx 01 84 00 EF BE AD DE, with the slave giving awready and wready in the same cycle and bresp=0 -> awaddr=0x0084, wdata=0xDEADBEEF, wstrb=F; tx 00.
- Read with delays: rx 02 10 00, slave arready after 3 cycles, rvalid after 5 with rdata=0x12345678, rresp=0 -> araddr=0x0010; tx 78 56 34 12 00.
- Split handshakes: write where wready comes 4 cycles after awready, and bresp=2 -> awvalid drops after its handshake, wvalid holds until wready; tx 02.
- Backpressure and back-to-back: read with tx_tready toggling every other cycle -> tx_tdata stable while stalled, 5 bytes in order; a second command is accepted immediately after.
- Bad opcode and timeout: rx 5A -> tx FF. Then rx 01 20 with RX_TIMEOUT=16 and 16 idle cycles -> rx_timeout_pulse=1, no tx, no AXI valids; next rx 02 00 00 is handled as a normal read.
- Reset: rstn low while awvalid=1 -> awvalid=0 and busy=0 immediately; after release, a normal read completes.
